instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 21 ++
 rtl/next_pc_logic.sv | 32 +++
 rtl/instruction_fetch_unit.sv | 109 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC default,
// the nop word and the J-type target helper.
package instruction_fetch_unit_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t StIdle  = 2'd0;
  localparam fetch_state_t StFetch = 2'd1;
  localparam fetch_state_t StValid = 2'd2;
  localparam fetch_state_t StHalt  = 2'd3;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
  localparam logic [31:0] Nop            = 32'h0000_0000;

  // J-type target keeps the top nibble of the sequential PC.
  function automatic logic [31:0] jump_addr(input logic [31:0] pc_plus4,
                                            input logic [25:0] target);
    return {pc_plus4[31:28], target, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: jr, then j, then taken branch, then fall-through.
// Also flags a jr whose target is not word aligned.
module next_pc_logic
  import instruction_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic        branch_i,
  input  logic        zero_i,
  input  logic        jump_i,
  input  logic        jump_reg_i,
  input  logic [31:0] branch_offset_i,
  input  logic [25:0] jump_target_i,
  input  logic [31:0] reg_target_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  always_comb begin
    next_pc_o = pc_plus4_i;
    if (jump_reg_i) begin
      next_pc_o = reg_target_i;
    end else if (jump_i) begin
      next_pc_o = jump_addr(pc_plus4_i, jump_target_i);
    end else if (branch_i && zero_i) begin
      // Wraps modulo 2^32; the offset's top two bits fall off the shift.
      next_pc_o = pc_plus4_i + (branch_offset_i << 2);
    end
  end

  assign misaligned_o = jump_reg_i & (|reg_target_i[1:0]);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch: request, capture, hold until the execute stage
// advances, then redirect. A misaligned jr parks the unit in HALT until reset.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [31:0] BranchOffset,
  input  logic [25:0] JumpTarget,
  input  logic [31:0] RegTarget,
  input  logic        Advance,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemRdata,
  output logic [31:0] Instruction,
  output logic [5:0]  Opcode,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        InstrValid,
  output logic        AddrError
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         addr_err_q, addr_err_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         misaligned;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_logic u_next_pc_logic (
    .pc_plus4_i      (pc_plus4),
    .branch_i        (Branch),
    .zero_i          (Zero),
    .jump_i          (Jump),
    .jump_reg_i      (JumpReg),
    .branch_offset_i (BranchOffset),
    .jump_target_i   (JumpTarget),
    .reg_target_i    (RegTarget),
    .next_pc_o       (next_pc),
    .misaligned_o    (misaligned)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    addr_err_d = addr_err_q;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        if (ImemAck) begin
          instr_d = ImemRdata;
          state_d = StValid;
        end
      end
      StValid: begin
        // Redirect inputs only matter on the consuming edge.
        if (Advance) begin
          if (misaligned) begin
            addr_err_d = 1'b1;
            state_d    = StHalt;
          end else begin
            pc_d    = next_pc;
            state_d = StFetch;
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_q    <= Nop;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign ImemReq     = (state_q == StFetch);
  assign ImemAddr    = pc_q;
  assign InstrValid  = (state_q == StValid);
  assign Instruction = instr_q;
  assign Opcode      = instr_q[31:26];
  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4;
  assign AddrError   = addr_err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed fetch/redirect/halt/reset
// scenarios against a transaction-level PC/instruction model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        Branch, Zero, Jump, JumpReg, Advance, ImemAck;
  logic [31:0] BranchOffset, RegTarget, ImemRdata;
  logic [25:0] JumpTarget;
  logic        ImemReq, InstrValid, AddrError;
  logic [31:0] ImemAddr, Instruction, PC, PCPlus4;
  logic [5:0]  Opcode;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: architectural PC, held instruction, sticky error, halted.
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic        exp_err;
  logic        exp_halt;

  instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Branch       (Branch),
    .Zero         (Zero),
    .Jump         (Jump),
    .JumpReg      (JumpReg),
    .BranchOffset (BranchOffset),
    .JumpTarget   (JumpTarget),
    .RegTarget    (RegTarget),
    .Advance      (Advance),
    .ImemReq      (ImemReq),
    .ImemAddr     (ImemAddr),
    .ImemAck      (ImemAck),
    .ImemRdata    (ImemRdata),
    .Instruction  (Instruction),
    .Opcode       (Opcode),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .InstrValid   (InstrValid),
    .AddrError    (AddrError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic br,
                                             input logic z, input logic j, input logic jr,
                                             input logic [31:0] off, input logic [25:0] tgt,
                                             input logic [31:0] rt);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (jr) return rt;
    if (j) return {seq[31:28], tgt, 2'b00};
    if (br && z) return seq + off * 32'd4;
    return seq;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check32("pc", PC, exp_pc);
    check32("pc_plus4", PCPlus4, exp_pc + 32'd4);
    check32("instruction", Instruction, exp_instr);
    check32("opcode", {26'd0, Opcode}, {26'd0, exp_instr[31:26]});
    check1("addr_error", AddrError, exp_err);
    check1("req_valid_exclusive", ImemReq & InstrValid, 1'b0);
    if (ImemReq) check32("imem_addr", ImemAddr, exp_pc);
    if (exp_halt || !rst_n) begin
      check1("quiet_req", ImemReq, 1'b0);
      check1("quiet_valid", InstrValid, 1'b0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirect;
    Branch = 1'b0; Zero = 1'b0; Jump = 1'b0; JumpReg = 1'b0;
    BranchOffset = '0; JumpTarget = '0; RegTarget = '0;
  endtask

  task automatic model_reset;
    exp_pc    = RESET_PC;
    exp_instr = 32'h0000_0000;
    exp_err   = 1'b0;
    exp_halt  = 1'b0;
  endtask

  // Assert reset mid-cycle, hold two edges, release mid-cycle (IDLE cycle follows).
  task automatic do_reset;
    rst_n = 1'b0;
    model_reset();
    #1;
    check1("req_in_reset", ImemReq, 1'b0);
    check1("valid_in_reset", InstrValid, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    check1("idle_no_req", ImemReq, 1'b0);
  endtask

  task automatic fetch(input int delay, output logic [31:0] addr, output int req_cycles);
    int guard;
    guard = 0;
    req_cycles = 0;
    addr = '0;
    while (!ImemReq && guard < 20) begin
      tick();
      guard++;
    end
    if (!ImemReq) begin
      check1("fetch_req_timeout", ImemReq, 1'b1);
      return;
    end
    addr = ImemAddr;
    for (int i = 0; i < delay; i++) begin
      // Advance and a misaligned jr outside VALID must be ignored.
      Advance = 1'b1; JumpReg = 1'b1; RegTarget = 32'h0000_0002;
      tick();
      req_cycles++;
      check1("req_held", ImemReq, 1'b1);
      check32("addr_stable", ImemAddr, addr);
    end
    Advance = 1'b0;
    clear_redirect();
    ImemAck = 1'b1;
    ImemRdata = mem_word(addr);
    tick();
    req_cycles++;
    ImemAck = 1'b0;
    ImemRdata = 32'hDEAD_BEEF;
    exp_instr = mem_word(addr);
    check1("valid_after_ack", InstrValid, 1'b1);
    check1("req_drop_after_ack", ImemReq, 1'b0);
  endtask

  task automatic advance(input int hold, input logic br, input logic z, input logic j,
                         input logic jr, input logic [31:0] off, input logic [25:0] tgt,
                         input logic [31:0] rt);
    logic [31:0] held;
    logic [31:0] nxt;
    held = Instruction;
    for (int i = 0; i < hold; i++) begin
      // Junk redirect and stray acks while Advance is low must not disturb anything.
      JumpReg = 1'b1; RegTarget = 32'h0000_0003; Jump = 1'b1;
      ImemAck = (i % 2 == 0); ImemRdata = 32'hFFFF_0000 + i;
      tick();
      check1("valid_held", InstrValid, 1'b1);
      check32("instr_held", Instruction, held);
    end
    ImemAck = 1'b0;
    Branch = br; Zero = z; Jump = j; JumpReg = jr;
    BranchOffset = off; JumpTarget = tgt; RegTarget = rt;
    Advance = 1'b1;
    nxt = model_next(exp_pc, br, z, j, jr, off, tgt, rt);
    tick();
    Advance = 1'b0;
    clear_redirect();
    if (jr && rt[1:0] != 2'b00) begin
      exp_halt = 1'b1;
      exp_err  = 1'b1;
    end else begin
      exp_pc = nxt;
      check1("valid_drops", InstrValid, 1'b0);
      check1("refetch_req", ImemReq, 1'b1);
    end
  endtask

  task automatic plain(input int hold);
    advance(hold, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0);
  endtask

  task automatic jr_to(input logic [31:0] t);
    logic [31:0] a;
    int rc;
    advance(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 26'h0, t);
    fetch(0, a, rc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int rc;
    int quiet;
    clear_redirect();
    Advance = 1'b0; ImemAck = 1'b0; ImemRdata = '0;
    model_reset();
    rst_n = 1'b1;
    #2;

    // Reset release, immediate acks: 0x0, 0x4, 0x8.
    do_reset();
    tick();
    check1("first_req_cycle2", ImemReq, 1'b1);
    check32("first_addr", ImemAddr, RESET_PC);
    fetch(0, a, rc);
    check32("seq_addr0", a, 32'h0000_0000);
    check32("min_latency", rc, 1);
    plain(0);
    fetch(0, a, rc);
    check32("seq_addr1", a, 32'h0000_0004);
    plain(0);
    fetch(0, a, rc);
    check32("seq_addr2", a, 32'h0000_0008);

    // Three wait states, Advance withheld for five cycles.
    plain(0);
    fetch(3, a, rc);
    check32("wait_addr", a, 32'h0000_000C);
    check32("req_cycles", rc, 4);
    advance(5, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 26'h0, 32'h0000_0100);

    // Branch taken backward / not taken.
    fetch(0, a, rc);
    check32("jr_addr_100", a, 32'h0000_0100);
    advance(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0);
    fetch(0, a, rc);
    check32("branch_taken", a, 32'h0000_00FC);
    jr_to(32'h0000_0100);
    advance(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0);
    fetch(0, a, rc);
    check32("branch_not_taken", a, 32'h0000_0104);

    // Jump, then priority of jr over j and branch.
    jr_to(32'h1000_0040);
    advance(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 26'h3, 32'h0);
    fetch(0, a, rc);
    check32("jump_addr", a, 32'h1000_000C);
    jr_to(32'h1000_0040);
    advance(0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 26'h3, 32'h0000_0200);
    fetch(0, a, rc);
    check32("jr_priority", a, 32'h0000_0200);

    // Sequential PC wraps at the top of the address space.
    jr_to(32'hFFFF_FFFC);
    check32("pcplus4_wrap", PCPlus4, 32'h0000_0000);
    plain(0);
    fetch(0, a, rc);
    check32("wrap_addr", a, 32'h0000_0000);

    // Misaligned jr: halt, sticky error, everything ignored.
    advance(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 26'h0, 32'h0000_0202);
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      Advance = 1'b1; ImemAck = 1'b1; JumpReg = 1'b1; RegTarget = 32'h0000_0300;
      tick();
      if (!ImemReq && !InstrValid) quiet++;
    end
    Advance = 1'b0; ImemAck = 1'b0;
    clear_redirect();
    check32("halt_quiet_cycles", quiet, 10);
    check1("halt_addr_error", AddrError, 1'b1);
    check32("halt_pc_kept", PC, 32'h0000_0000);
    do_reset();
    check1("reset_clears_error", AddrError, 1'b0);
    fetch(0, a, rc);
    check32("refetch_after_halt", a, RESET_PC);

    // Reset while a request is outstanding; late ack must be dropped.
    plain(0);
    tick();
    check1("req_pending", ImemReq, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check1("req_abandoned", ImemReq, 1'b0);
    ImemAck = 1'b1;
    ImemRdata = 32'hBAD0_0BAD;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    ImemAck = 1'b0;
    check1("late_ack_ignored", InstrValid, 1'b0);
    check1("post_reset_req", ImemReq, 1'b1);
    check32("post_reset_addr", ImemAddr, RESET_PC);
    check32("nop_after_late_ack", Instruction, 32'h0000_0000);
    fetch(0, a, rc);
    check32("post_reset_fetch", a, RESET_PC);
    plain(0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
